support_fifo_port: RTL and testbench

Byte-wide mailbox device occupying one of the 16 slots behind the Z80 support I/O switch. Z80 `OUT` writes reach it as Wishbone write strobes and are pushed into a TX FIFO drained by the support CPU. Z80 `IN` reads return bytes from an RX FIFO filled by the support CPU, popped at the end of each read cycle. A status register exposes FIFO state and sticky error flags.

---
 rtl/support_fifo_pkg.sv | 20 ++
 rtl/support_fifo_buf.sv | 90 +++++++++
 rtl/support_fifo_port.sv | 150 +++++++++++++++
 tb/tb_support_fifo_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/support_fifo_pkg.sv
// support_fifo_pkg: register map, status and control bit indices
// for the Z80 support mailbox port.
package support_fifo_pkg;

  localparam logic [3:0] REG_DATA   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_UDF   = 3;
  localparam int ST_IRQ_EN   = 7;

  localparam int CTL_CLR   = 0;
  localparam int CTL_FLUSH = 1;
  localparam int CTL_IRQEN = 7;

  localparam logic [7:0] RD_IDLE = 8'hff;

endpackage

// File: rtl/support_fifo_buf.sv
// support_fifo_buf: byte FIFO with flush, registered head and
// registered empty/full flags.
module support_fifo_buf
  import support_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] dat_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    head_q, head_d;
  logic          empty_q, full_q;
  logic          pop_ok, push_ok;

  // a pop frees room, so a full FIFO still takes a same-cycle push
  assign pop_ok  = pop_i & !empty_q;
  assign push_ok = push_i & (!full_q | pop_ok);

  assign head_o  = head_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

  // pointer, count and head next-state; flush wins over push/pop
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop_ok)  rp_d = rp_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (pop_ok) begin
        if (cnt_q > ONE_CNT) head_d = mem_q[rp_d];
        else if (push_ok)    head_d = dat_i;
      end else if (push_ok && empty_q) begin
        head_d = dat_i;
      end
    end
  end

  // state registers; flags track the next count
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      head_q  <= RD_IDLE;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == FULL_CNT);
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wp_q] <= dat_i;
  end

endmodule

// File: rtl/support_fifo_port.sv
// support_fifo_port: Z80 mailbox slot, TX/RX FIFOs plus status.
// SUPPORT_FIFO_IRQ_EN adds nint_o and the stored irq_en bit.
module support_fifo_port
  import support_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic [3:0] A_i,
  input  logic       nrd_i,
  input  logic       nwr_i,
  output logic [7:0] io_o,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  input  logic [7:0] rx_dat_i,
  input  logic       rx_wr_i,
  output logic       rx_full_o,
  output logic [7:0] tx_dat_o,
  input  logic       tx_rd_i,
  output logic       tx_empty_o
`ifdef SUPPORT_FIFO_IRQ_EN
  ,
  output logic       nint_o
`endif
);

  logic       arm_q, arm_d;
  logic       ack_q;
  logic       nrd_q;
  logic [3:0] rd_adr_q, rd_adr_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_udf_q, rx_udf_d;
  logic       irq_en;
  logic       accept, wr_en, tx_push, ctl_wr;
  logic       flush, rx_pop;
  logic       tx_full, rx_empty;
  logic [7:0] rx_head, status;
  logic       unused_bits;

  assign accept  = stb_i & arm_q;
  assign wr_en   = accept & we_i;
  assign tx_push = wr_en & (adr_i[3:0] == REG_DATA);
  assign ctl_wr  = wr_en & (adr_i[3:0] == REG_STATUS);
  assign flush   = ctl_wr & dat_i[CTL_FLUSH];
  assign rx_pop  = nrd_i & !nrd_q & (rd_adr_q == REG_DATA);
  assign ack_o   = ack_q;

  support_fifo_buf #(.DEPTH(DEPTH), .AW(AW)) u_tx (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .flush_i  (flush),
    .push_i   (tx_push),
    .dat_i    (dat_i),
    .pop_i    (tx_rd_i),
    .head_o   (tx_dat_o),
    .empty_o  (tx_empty_o),
    .full_o   (tx_full)
  );

  support_fifo_buf #(.DEPTH(DEPTH), .AW(AW)) u_rx (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .flush_i  (flush),
    .push_i   (rx_wr_i),
    .dat_i    (rx_dat_i),
    .pop_i    (rx_pop),
    .head_o   (rx_head),
    .empty_o  (rx_empty),
    .full_o   (rx_full_o)
  );

  // arm/read-address/sticky-flag next state; a set beats a clear
  always_comb begin
    arm_d    = arm_q;
    rd_adr_d = rd_adr_q;
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (accept)     arm_d = 1'b0;
    else if (nwr_i) arm_d = 1'b1;
    if (!nrd_i) rd_adr_d = A_i;
    if (ctl_wr && dat_i[CTL_CLR]) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
    end
    if (tx_push && tx_full && !tx_rd_i) tx_ovf_d = 1'b1;
    if (rx_pop && rx_empty) rx_udf_d = 1'b1;
  end

  // handshake and flag registers
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      arm_q    <= 1'b1;
      ack_q    <= 1'b0;
      nrd_q    <= 1'b1;
      rd_adr_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      arm_q    <= arm_d;
      ack_q    <= stb_i;
      nrd_q    <= nrd_i;
      rd_adr_q <= rd_adr_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

`ifdef SUPPORT_FIFO_IRQ_EN
  logic irq_en_q, nint_q;
  assign irq_en      = irq_en_q;
  assign nint_o      = nint_q;
  assign unused_bits = ^adr_i[7:4];

  // interrupt enable and registered active-low request
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      irq_en_q <= 1'b0;
      nint_q   <= 1'b1;
    end else begin
      if (ctl_wr) irq_en_q <= dat_i[CTL_IRQEN];
      nint_q <= !(irq_en_q & (!rx_empty | tx_ovf_q | rx_udf_q));
    end
  end
`else
  assign irq_en      = 1'b0;
  assign unused_bits = ^{adr_i[7:4], dat_i[CTL_IRQEN]};
`endif

  // Z80 read mux, combinational from A_i
  always_comb begin
    status = '0;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_UDF]   = rx_udf_q;
    status[ST_IRQ_EN]   = irq_en;
    io_o = RD_IDLE;
    unique case (1'b1)
      (A_i == REG_DATA):   io_o = rx_empty ? RD_IDLE : rx_head;
      (A_i == REG_STATUS): io_o = status;
      default:             io_o = RD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_support_fifo_port.sv
// tb_support_fifo_port: directed plan items plus randomized traffic
// checked against a queue-based model of the mailbox.
`timescale 1ns/1ps
module tb_support_fifo_port;

  localparam int DEPTH = 16;
`ifdef SUPPORT_FIFO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset_i = 1'b0;
  logic [3:0] A_i = '0;
  logic       nrd_i = 1'b1, nwr_i = 1'b1;
  logic [7:0] io_o;
  logic       stb_i = 1'b0, we_i = 1'b0;
  logic [7:0] adr_i = '0, dat_i = '0;
  logic       ack_o;
  logic [7:0] rx_dat_i = '0;
  logic       rx_wr_i = 1'b0, rx_full_o;
  logic [7:0] tx_dat_o;
  logic       tx_rd_i = 1'b0, tx_empty_o;
  logic       nint_o;

  always #5 clk = ~clk;

  support_fifo_port #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .nreset_i(nreset_i), .A_i(A_i),
    .nrd_i(nrd_i), .nwr_i(nwr_i), .io_o(io_o),
    .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .ack_o(ack_o),
    .rx_dat_i(rx_dat_i), .rx_wr_i(rx_wr_i),
    .rx_full_o(rx_full_o), .tx_dat_o(tx_dat_o),
    .tx_rd_i(tx_rd_i), .tx_empty_o(tx_empty_o)
`ifdef SUPPORT_FIFO_IRQ_EN
    , .nint_o(nint_o)
`endif
  );
`ifndef SUPPORT_FIFO_IRQ_EN
  assign nint_o = 1'b1;
`endif

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0] tx_q[$], rx_q[$];
  bit         m_arm, m_ovf, m_udf, m_irq, m_nrd_prev, m_ack, m_nint;
  logic [3:0] m_rd_adr;
  logic [7:0] m_tx_dat;

  function automatic void m_reset();
    tx_q.delete(); rx_q.delete();
    m_arm = 1; m_ovf = 0; m_udf = 0; m_irq = 0;
    m_nrd_prev = 1; m_ack = 0; m_nint = 1;
    m_rd_adr = 0; m_tx_dat = 8'hff;
  endfunction

  function automatic logic [7:0] exp_io(input logic [3:0] a);
    logic [7:0] s;
    s = {m_irq, 3'b000, m_udf, m_ovf, tx_q.size() == DEPTH,
         rx_q.size() != 0};
    if (a == 4'd0) return (rx_q.size() != 0) ? rx_q[0] : 8'hff;
    if (a == 4'd1) return s;
    return 8'hff;
  endfunction

  // one clock: advance the model on the current inputs, then compare
  task automatic step();
    bit acc, wr, push, ctl, pop_req, nint_n;
    if (!nreset_i) m_reset();
    else begin
      acc     = stb_i && m_arm;
      wr      = acc && we_i;
      push    = wr && adr_i[3:0] == 4'd0;
      ctl     = wr && adr_i[3:0] == 4'd1;
      pop_req = nrd_i && !m_nrd_prev && m_rd_adr == 4'd0;
      nint_n  = !(m_irq && (rx_q.size() != 0 || m_ovf || m_udf));
      if (ctl && dat_i[0]) begin m_ovf = 0; m_udf = 0; end
      if (push && tx_q.size() == DEPTH && !tx_rd_i) m_ovf = 1;
      if (pop_req && rx_q.size() == 0) m_udf = 1;
      if (ctl && dat_i[1]) begin
        tx_q.delete(); rx_q.delete();
      end else begin
        if (tx_rd_i && tx_q.size() != 0) void'(tx_q.pop_front());
        if (push && tx_q.size() < DEPTH) tx_q.push_back(dat_i);
        if (pop_req && rx_q.size() != 0) void'(rx_q.pop_front());
        if (rx_wr_i && rx_q.size() < DEPTH) rx_q.push_back(rx_dat_i);
      end
      if (ctl && IRQ) m_irq = dat_i[7];
      if (acc) m_arm = 0; else if (nwr_i) m_arm = 1;
      if (!nrd_i) m_rd_adr = A_i;
      m_nrd_prev = nrd_i;
      m_ack = stb_i;
      if (tx_q.size() != 0) m_tx_dat = tx_q[0];
      m_nint = nint_n;
    end
    @(posedge clk);
    #1;
    chk("ack", ack_o, m_ack);
    chk("tx_empty", tx_empty_o, tx_q.size() == 0);
    chk("rx_full", rx_full_o, rx_q.size() == DEPTH);
    chk("tx_dat", tx_dat_o, m_tx_dat);
    if (IRQ) chk("nint", nint_o, m_nint);
    if (!nrd_i) chk("io", io_o, exp_io(A_i));
  endtask

  task automatic idle();
    stb_i = 0; we_i = 0; nwr_i = 1; nrd_i = 1;
    rx_wr_i = 0; tx_rd_i = 0;
  endtask

  task automatic do_reset();
    idle();
    nreset_i = 0; step(); step();
    nreset_i = 1; step();
  endtask

  // one Z80 OUT: nwr low, single strobe, nwr high
  task automatic wb_wr(input logic [3:0] a, input logic [7:0] d);
    nwr_i = 0; step();
    stb_i = 1; we_i = 1; adr_i = {4'h0, a}; dat_i = d; step();
    stb_i = 0; we_i = 0; nwr_i = 1; step();
  endtask

  // one Z80 IN: returns io_o sampled while nrd is low
  task automatic z80_rd(input logic [3:0] a, output logic [7:0] v);
    A_i = a; nrd_i = 0; step();
    v = io_o;
    nrd_i = 1; step(); step();
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_wr_i = 1; rx_dat_i = d; step(); rx_wr_i = 0;
  endtask

  task automatic rand_phase(input int n, input int p_txrd);
    for (int c = 0; c < n; c++) begin
      int r;
      nreset_i = ($urandom_range(0, 599) != 0);
      nwr_i    = ($urandom_range(0, 2) != 0);
      stb_i    = $urandom_range(0, 1);
      we_i     = $urandom_range(0, 1);
      r        = $urandom_range(0, 15);
      adr_i    = (r == 0) ? 8'h01 : (r < 11) ? 8'h00 : 8'($urandom);
      dat_i    = 8'($urandom);
      A_i      = 4'($urandom_range(0, 3));
      nrd_i    = ($urandom_range(0, 2) != 0);
      rx_wr_i  = ($urandom_range(0, 2) == 0);
      rx_dat_i = 8'($urandom);
      tx_rd_i  = ($urandom_range(0, 99) < p_txrd);
      step();
    end
    nreset_i = 1; idle();
  endtask

  initial begin
    logic [7:0] v;
    int acks;
    m_reset();

    // reset values
    do_reset();
    chk("rst_ack", ack_o, 0);
    chk("rst_txe", tx_empty_o, 1);
    chk("rst_rxf", rx_full_o, 0);
    chk("rst_txd", tx_dat_o, 8'hff);
    chk("rst_nint", nint_o, 1);

    // held write with re-strobes pushes once
    nwr_i = 0; acks = 0;
    for (int i = 0; i < 6; i++) begin
      stb_i = (i % 2 == 0); we_i = 1; adr_i = 8'h00; dat_i = 8'h5a;
      step();
      if (ack_o) acks++;
    end
    idle(); step();
    chk("held_acks", acks, 3);
    chk("held_txd", tx_dat_o, 8'h5a);
    tx_rd_i = 1; step(); tx_rd_i = 0;
    chk("held_once", tx_empty_o, 1);

    // RX reads in order, then underflow
    do_reset();
    rx_push(8'h11); rx_push(8'h22);
    z80_rd(0, v); chk("rd0", v, 8'h11);
    z80_rd(0, v); chk("rd1", v, 8'h22);
    z80_rd(0, v); chk("rd2", v, 8'hff);
    z80_rd(1, v); chk("st_udf", v, 8'h08);
    z80_rd(5, v); chk("rd_hi", v, 8'hff);

    // 17 writes overflow, then drain in order
    do_reset();
    for (int i = 0; i < 17; i++) wb_wr(0, 8'(i));
    z80_rd(1, v); chk("st_ovf", v, 8'h06);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain", tx_dat_o, i);
      tx_rd_i = 1; step(); tx_rd_i = 0;
    end
    chk("drained", tx_empty_o, 1);

    // write to full TX with same-cycle pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) wb_wr(0, 8'(i + 8'h40));
    nwr_i = 0; step();
    stb_i = 1; we_i = 1; adr_i = 8'h00; dat_i = 8'hee; tx_rd_i = 1;
    step();
    idle(); step();
    z80_rd(1, v); chk("st_full_pop", v, 8'h02);

    // control write: flush both plus irq_en
    do_reset();
    rx_push(8'h33); wb_wr(0, 8'h44);
    wb_wr(1, 8'h82);
    chk("fl_txe", tx_empty_o, 1);
    z80_rd(1, v); chk("st_flush", v, IRQ ? 8'h80 : 8'h00);
    rx_push(8'h55);
    chk("nint_pre", nint_o, 1);
    step();
    chk("nint_on", nint_o, IRQ ? 1'b0 : 1'b1);

    // reset mid-write; held strobe then accepted once
    do_reset();
    nwr_i = 0; step();
    stb_i = 1; we_i = 1; adr_i = 8'h00; dat_i = 8'h77;
    nreset_i = 0; step(); step();
    chk("mid_ack", ack_o, 0);
    chk("mid_txe", tx_empty_o, 1);
    chk("mid_txd", tx_dat_o, 8'hff);
    nreset_i = 1; step(); step(); step();
    idle(); step();
    chk("mid_txd2", tx_dat_o, 8'h77);
    tx_rd_i = 1; step(); tx_rd_i = 0;
    chk("mid_once", tx_empty_o, 1);

    // randomized traffic
    do_reset();
    rand_phase(2000, 25);
    rand_phase(1500, 3);
    rand_phase(1500, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
